// File: rtl/hazard_unit.sv
// Pipeline hazard unit: detects load-use and branch-operand hazards for the ID
// instruction, requests a stall bubble, and tracks stall/flush statistics.
module hazard_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  ID_opcode,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        EX_MemRead,
    input  logic        EX_RegWrite,
    input  logic [4:0]  EX_dst,
    input  logic        MEM_MemRead,
    input  logic [4:0]  MEM_dst,
    input  logic        IF_Flush,
    output logic        hazard_detected,
    output logic        PC_Write,
    output logic        IFID_Write,
    output logic [15:0] stall_cycles,
    output logic [15:0] flush_cycles,
    output logic        hazard_error,
    output logic [1:0]  stall_state
);

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpBeq   = 6'b000100;

    localparam logic [15:0] CntMax = 16'hFFFF;

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StStall1 = 2'b01,
        StStall2 = 2'b10
    } stall_st_e;

    stall_st_e   state_q;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;
    logic        error_q, error_d;

    logic uses_rs, uses_rt, is_beq;
    logic match_ex, match_mem;
    logic load_use, br_alu, br_load, hz;

    // Decode which source fields the ID instruction actually reads.
    always_comb begin
        uses_rs = 1'b0;
        uses_rt = 1'b0;
        unique case (ID_opcode)
            OpRtype, OpSw, OpBeq: begin
                uses_rs = 1'b1;
                uses_rt = 1'b1;
            end
            OpLw, OpAddi: uses_rs = 1'b1;
            default: ;
        endcase
    end

    // Dependency matching and hazard classification; $zero never creates a dependency.
    always_comb begin
        is_beq    = (ID_opcode == OpBeq);
        match_ex  = (EX_dst != 5'd0) &&
                    ((uses_rs && (ID_rs == EX_dst)) || (uses_rt && (ID_rt == EX_dst)));
        match_mem = (MEM_dst != 5'd0) &&
                    ((uses_rs && (ID_rs == MEM_dst)) || (uses_rt && (ID_rt == MEM_dst)));
        load_use  = EX_MemRead && match_ex;
        // An ALU result in EX cannot yet be forwarded to the branch comparator in ID.
        br_alu    = is_beq && EX_RegWrite && !EX_MemRead && match_ex;
        // A load result is only available after MEM, so a branch waits one more cycle.
        br_load   = is_beq && MEM_MemRead && match_mem;
        hz        = load_use || br_alu || br_load;
    end

    // Zero-latency stall outputs, all forced low while reset is held.
    always_comb begin
        hazard_detected = hz && rst_n;
        PC_Write        = !hz && rst_n;
        IFID_Write      = !hz && rst_n;
    end

    // Stall-depth FSM: counts consecutive stall cycles up to STALL2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            case (state_q)
                StRun:    state_q <= hz ? StStall1 : StRun;
                StStall1: state_q <= hz ? StStall2 : StRun;
                StStall2: state_q <= hz ? StStall2 : StRun;
                default:  state_q <= StRun;
            endcase
        end
    end

    // Next-state for saturating counters and the sticky error flag.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        error_d     = error_q;
        if (hz) begin
            if (stall_cnt_q != CntMax) stall_cnt_d = stall_cnt_q + 16'd1;
        end else if (IF_Flush) begin
            // A stall takes priority, so a flush is only counted on a free cycle.
            if (flush_cnt_q != CntMax) flush_cnt_d = flush_cnt_q + 16'd1;
        end
        // Third consecutive stall cycle means the pipeline is stuck.
        if ((state_q == StStall2) && hz) error_d = 1'b1;
    end

    // Statistics and error registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            error_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            error_q     <= error_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_cycles = flush_cnt_q;
    assign hazard_error = error_q;
    assign stall_state  = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized
// stimulus against a rule-level reference model.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  ID_opcode;
    logic [4:0]  ID_rs, ID_rt;
    logic        EX_MemRead, EX_RegWrite;
    logic [4:0]  EX_dst;
    logic        MEM_MemRead;
    logic [4:0]  MEM_dst;
    logic        IF_Flush;
    logic        hazard_detected, PC_Write, IFID_Write, hazard_error;
    logic [15:0] stall_cycles, flush_cycles;
    logic [1:0]  stall_state;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: consecutive-stall streak, counts and error flag.
    int m_streak, m_stall, m_flush;
    bit m_err;

    hazard_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_opcode       (ID_opcode),
        .ID_rs           (ID_rs),
        .ID_rt           (ID_rt),
        .EX_MemRead      (EX_MemRead),
        .EX_RegWrite     (EX_RegWrite),
        .EX_dst          (EX_dst),
        .MEM_MemRead     (MEM_MemRead),
        .MEM_dst         (MEM_dst),
        .IF_Flush        (IF_Flush),
        .hazard_detected (hazard_detected),
        .PC_Write        (PC_Write),
        .IFID_Write      (IFID_Write),
        .stall_cycles    (stall_cycles),
        .flush_cycles    (flush_cycles),
        .hazard_error    (hazard_error),
        .stall_state     (stall_state)
    );

    always #5 clk = ~clk;

    function automatic bit model_hz();
        bit rs_used, rt_used, beq, dep_ex, dep_mem;
        rs_used = ID_opcode inside {6'o00, 6'b100011, 6'b101011, 6'b001000, 6'b000100};
        rt_used = ID_opcode inside {6'o00, 6'b101011, 6'b000100};
        beq     = (ID_opcode == 6'b000100);
        dep_ex  = (EX_dst != 0) &&
                  ((rs_used && ID_rs == EX_dst) || (rt_used && ID_rt == EX_dst));
        dep_mem = (MEM_dst != 0) &&
                  ((rs_used && ID_rs == MEM_dst) || (rt_used && ID_rt == MEM_dst));
        return (EX_MemRead && dep_ex) || (beq && EX_RegWrite && !EX_MemRead && dep_ex) ||
               (beq && MEM_MemRead && dep_mem);
    endfunction

    task automatic model_reset();
        m_streak = 0;
        m_stall  = 0;
        m_flush  = 0;
        m_err    = 0;
    endtask

    task automatic clear_inputs();
        ID_opcode   = 6'b000010;
        ID_rs       = 0;
        ID_rt       = 0;
        EX_MemRead  = 0;
        EX_RegWrite = 0;
        EX_dst      = 0;
        MEM_MemRead = 0;
        MEM_dst     = 0;
        IF_Flush    = 0;
    endtask

    // Advance one rising edge, updating the model with the pre-edge inputs.
    task automatic tick();
        bit h;
        h = model_hz();
        @(posedge clk);
        if (h) begin
            if (m_streak == 2) m_err = 1;
            if (m_streak < 2) m_streak++;
            if (m_stall < 65535) m_stall++;
        end else begin
            m_streak = 0;
            if (IF_Flush && m_flush < 65535) m_flush++;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        #7;
        @(negedge clk);
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 0;
        clear_inputs();
        EX_MemRead = 1; EX_dst = 8; ID_opcode = 0; ID_rs = 8; IF_Flush = 1;
        repeat (2) @(posedge clk);
        #2;
        n_vec++; if (hazard_detected !== 1'b0) begin n_err++;
            $display("FAIL rst_hd: got %b want 0", hazard_detected); end
        n_vec++; if (PC_Write !== 1'b0 || IFID_Write !== 1'b0) begin n_err++;
            $display("FAIL rst_we: got %b%b want 00", PC_Write, IFID_Write); end
        n_vec++; if (stall_state !== 2'b00 || hazard_error !== 1'b0) begin n_err++;
            $display("FAIL rst_st: got %b/%b want 00/0", stall_state, hazard_error); end
        n_vec++; if (stall_cycles !== 16'd0 || flush_cycles !== 16'd0) begin n_err++;
            $display("FAIL rst_cnt: got %0d/%0d want 0/0", stall_cycles, flush_cycles); end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        #1;
        n_vec++; if (hazard_detected !== 1'b1 || PC_Write !== 1'b0) begin n_err++;
            $display("FAIL rst_rel: got hd=%b pcw=%b want 1/0", hazard_detected, PC_Write); end
        tick();
        n_vec++; if (stall_cycles !== 16'd1 || flush_cycles !== 16'd0) begin n_err++;
            $display("FAIL rst_first: got %0d/%0d want 1/0", stall_cycles, flush_cycles); end
    endtask

    task automatic test_load_use();
        do_reset();
        EX_MemRead = 1; EX_dst = 8; ID_opcode = 6'b000000; ID_rs = 8; ID_rt = 2;
        #1;
        n_vec++; if (hazard_detected !== 1'b1 || PC_Write !== 1'b0 || IFID_Write !== 1'b0) begin
            n_err++; $display("FAIL lu_hz: got %b%b%b want 100", hazard_detected, PC_Write,
                              IFID_Write); end
        tick();
        n_vec++; if (stall_state !== 2'b01 || stall_cycles !== 16'd1) begin n_err++;
            $display("FAIL lu_st1: got %b/%0d want 01/1", stall_state, stall_cycles); end
        EX_MemRead = 0; EX_dst = 0;
        #1;
        n_vec++; if (hazard_detected !== 1'b0 || PC_Write !== 1'b1) begin n_err++;
            $display("FAIL lu_clr: got %b/%b want 0/1", hazard_detected, PC_Write); end
        tick();
        n_vec++; if (stall_state !== 2'b00 || stall_cycles !== 16'd1) begin n_err++;
            $display("FAIL lu_run: got %b/%0d want 00/1", stall_state, stall_cycles); end
    endtask

    task automatic test_zero_and_rt_mask();
        do_reset();
        EX_MemRead = 1; EX_dst = 0; ID_opcode = 6'b000000; ID_rs = 0; ID_rt = 0;
        #1;
        n_vec++; if (hazard_detected !== 1'b0) begin n_err++;
            $display("FAIL zero_reg: got %b want 0", hazard_detected); end
        ID_opcode = 6'b001000; ID_rs = 1; ID_rt = 9; EX_dst = 9;
        #1;
        n_vec++; if (hazard_detected !== 1'b0) begin n_err++;
            $display("FAIL addi_rt: got %b want 0", hazard_detected); end
        ID_opcode = 6'b101011;
        #1;
        n_vec++; if (hazard_detected !== 1'b1) begin n_err++;
            $display("FAIL sw_rt: got %b want 1", hazard_detected); end
    endtask

    task automatic test_branch_load();
        do_reset();
        ID_opcode = 6'b000100; ID_rs = 5; ID_rt = 7;
        EX_MemRead = 1; EX_dst = 5;
        #1;
        n_vec++; if (hazard_detected !== 1'b1) begin n_err++;
            $display("FAIL bl_c1: got %b want 1", hazard_detected); end
        tick();
        EX_MemRead = 0; EX_dst = 0; MEM_MemRead = 1; MEM_dst = 5;
        #1;
        n_vec++; if (hazard_detected !== 1'b1 || stall_state !== 2'b01) begin n_err++;
            $display("FAIL bl_c2: got %b/%b want 1/01", hazard_detected, stall_state); end
        tick();
        MEM_MemRead = 0; MEM_dst = 0;
        #1;
        n_vec++; if (hazard_detected !== 1'b0 || stall_state !== 2'b10) begin n_err++;
            $display("FAIL bl_c3: got %b/%b want 0/10", hazard_detected, stall_state); end
        tick();
        n_vec++; if (stall_cycles !== 16'd2 || hazard_error !== 1'b0 || stall_state !== 2'b00)
            begin n_err++; $display("FAIL bl_end: got %0d/%b/%b want 2/0/00", stall_cycles,
                                    hazard_error, stall_state); end
    endtask

    task automatic test_branch_alu();
        do_reset();
        ID_opcode = 6'b000100; ID_rs = 1; ID_rt = 3;
        EX_RegWrite = 1; EX_MemRead = 0; EX_dst = 3;
        #1;
        n_vec++; if (hazard_detected !== 1'b1) begin n_err++;
            $display("FAIL ba_hz: got %b want 1", hazard_detected); end
        tick();
        EX_RegWrite = 0; EX_dst = 0;
        #1;
        n_vec++; if (hazard_detected !== 1'b0 || stall_cycles !== 16'd1) begin n_err++;
            $display("FAIL ba_one: got %b/%0d want 0/1", hazard_detected, stall_cycles); end
        // Same ALU dependency on a non-branch is handled by forwarding, not a stall.
        ID_opcode = 6'b000000; EX_RegWrite = 1; EX_dst = 3;
        #1;
        n_vec++; if (hazard_detected !== 1'b0) begin n_err++;
            $display("FAIL ba_rtype: got %b want 0", hazard_detected); end
    endtask

    task automatic test_flush();
        do_reset();
        IF_Flush = 1;
        #1;
        n_vec++; if (PC_Write !== 1'b1 || IFID_Write !== 1'b1) begin n_err++;
            $display("FAIL fl_we: got %b%b want 11", PC_Write, IFID_Write); end
        repeat (3) tick();
        n_vec++; if (flush_cycles !== 16'd3 || stall_state !== 2'b00) begin n_err++;
            $display("FAIL fl_cnt: got %0d/%b want 3/00", flush_cycles, stall_state); end
        EX_MemRead = 1; EX_dst = 4; ID_opcode = 6'b100011; ID_rs = 4;
        tick();
        n_vec++; if (flush_cycles !== 16'd3 || stall_cycles !== 16'd1) begin n_err++;
            $display("FAIL fl_prio: got %0d/%0d want 3/1", flush_cycles, stall_cycles); end
    endtask

    task automatic test_random();
        logic [5:0] ops [7];
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b001000, 6'b000100, 6'b000010, 6'b001101};
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ID_opcode   = ops[$urandom_range(0, 6)];
            ID_rs       = 5'($urandom_range(0, 3));
            ID_rt       = 5'($urandom_range(0, 3));
            EX_MemRead  = 1'($urandom_range(0, 1));
            EX_RegWrite = 1'($urandom_range(0, 1));
            EX_dst      = 5'($urandom_range(0, 3));
            MEM_MemRead = 1'($urandom_range(0, 1));
            MEM_dst     = 5'($urandom_range(0, 3));
            IF_Flush    = 1'($urandom_range(0, 1));
            #1;
            n_vec++; if (hazard_detected !== model_hz() || PC_Write !== !model_hz() ||
                         IFID_Write !== !model_hz()) begin n_err++;
                $display("FAIL rnd_hz[%0d]: got %b%b%b want hz=%b", i, hazard_detected,
                         PC_Write, IFID_Write, model_hz()); end
            tick();
            n_vec++; if (stall_state !== 2'(m_streak) || hazard_error !== m_err) begin n_err++;
                $display("FAIL rnd_st[%0d]: got %b/%b want %0d/%b", i, stall_state,
                         hazard_error, m_streak, m_err); end
            n_vec++; if (stall_cycles !== 16'(m_stall) || flush_cycles !== 16'(m_flush)) begin
                n_err++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i,
                                  stall_cycles, flush_cycles, m_stall, m_flush); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        EX_MemRead = 1; EX_dst = 8; ID_opcode = 6'b000000; ID_rs = 8;
        repeat (70000) tick();
        n_vec++; if (stall_cycles !== 16'hFFFF || m_stall != 65535) begin n_err++;
            $display("FAIL sat_cnt: got %0h want ffff", stall_cycles); end
        n_vec++; if (hazard_error !== 1'b1 || stall_state !== 2'b10) begin n_err++;
            $display("FAIL sat_err: got %b/%b want 1/10", hazard_error, stall_state); end
    endtask

    task automatic test_async_reset();
        // Still stalled in STALL2 from the saturation run; reset away from any edge.
        #2;
        rst_n = 0;
        #1;
        n_vec++; if (stall_state !== 2'b00 || hazard_error !== 1'b0) begin n_err++;
            $display("FAIL ar_st: got %b/%b want 00/0", stall_state, hazard_error); end
        n_vec++; if (stall_cycles !== 16'd0 || flush_cycles !== 16'd0) begin n_err++;
            $display("FAIL ar_cnt: got %0d/%0d want 0/0", stall_cycles, flush_cycles); end
        n_vec++; if (PC_Write !== 1'b0 || hazard_detected !== 1'b0) begin n_err++;
            $display("FAIL ar_out: got pcw=%b hd=%b want 0/0", PC_Write, hazard_detected); end
        @(negedge clk);
        rst_n = 1;
        model_reset();
        tick();
        n_vec++; if (stall_state !== 2'b01 || stall_cycles !== 16'd1) begin n_err++;
            $display("FAIL ar_fresh: got %b/%0d want 01/1", stall_state, stall_cycles); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_zero_and_rt_mask();
        test_branch_load();
        test_branch_alu();
        test_flush();
        test_random();
        test_saturation();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 ID_opcode  input  6  opcode of the instruction in ID.
REQ-004 ID_rs, ID_rt  input  5 each  source register fields of the ID instruction.
REQ-005 EX_MemRead, EX_RegWrite  input  1 each  control bits of the instruction in EX.
REQ-006 EX_dst  input  5  destination register of the EX instruction (already muxed by RegDst).
REQ-007 MEM_MemRead  input  1  MemRead of the instruction in MEM.
REQ-008 MEM_dst  input  5  destination register of the MEM instruction.
REQ-009 IF_Flush  input  1  branch-taken flush request from the main decoder.
REQ-010 hazard_detected  output  1  stall request; drives the main decoder's hazard_detected input (control bubble).
REQ-011 PC_Write, IFID_Write  output  1 each  write enables for the PC and IF/ID registers.
REQ-012 stall_cycles, flush_cycles  output  16 each  saturating event counters.
REQ-013 hazard_error  output  1  sticky error flag.
REQ-014 stall_state  output  2  FSM state: RUN=00, STALL1=01, STALL2=10.

Function
REQ-015 uses_rs SHALL be 1 for opcodes 000000, 100011, 101011, 001000, 000100; uses_rt SHALL be 1 for 000000, 101011, 000100 only.
REQ-016 match_EX SHALL be (uses_rs and ID_rs==EX_dst) or (uses_rt and ID_rt==EX_dst), and SHALL be forced to 0 when EX_dst==0. match_MEM is defined the same way against MEM_dst.
REQ-017 load_use SHALL be EX_MemRead and match_EX.
REQ-018 br_alu SHALL be (ID_opcode==000100) and EX_RegWrite and not EX_MemRead and match_EX.
REQ-019 br_load SHALL be (ID_opcode==000100) and MEM_MemRead and match_MEM.
REQ-020 hz SHALL be load_use or br_alu or br_load; this is combinational from the current inputs.
REQ-021 hazard_detected SHALL equal hz, with PC_Write = IFID_Write = not hz, with zero latency.
REQ-022 The FSM SHALL make the following transitions on each edge:
 - RUN goes to STALL1 if hz, otherwise stays in RUN.
 - STALL1 goes to STALL2 if hz, otherwise returns to RUN.
 - STALL2 stays in STALL2 if hz, otherwise returns to RUN.
REQ-023 A branch depending on a load SHALL produce exactly 2 consecutive stall cycles: EX load_use, then MEM br_load.
REQ-024 hazard_error SHALL set on any edge where the state is STALL2 and hz is 1 (third consecutive stall); it SHALL stay set until reset.
REQ-025 stall_cycles SHALL increment by 1 on each edge with hz=1, and SHALL saturate at 16'hFFFF with no wrap.
REQ-026 flush_cycles SHALL increment by 1 on each edge with IF_Flush=1 and hz=0, and SHALL saturate at 16'hFFFF.
REQ-027 When IF_Flush and hz are both 1, the hazard SHALL take priority: the stall is counted and the flush is not.
REQ-028 IF_Flush SHALL have no effect on the FSM, PC_Write or IFID_Write.

Reset
REQ-029 While rst_n=0 the following SHALL hold immediately, independent of clk:
 - stall_state=RUN; stall_cycles=0; flush_cycles=0; hazard_error=0.
 - hazard_detected=0; PC_Write=0; IFID_Write=0.
REQ-030 After rst_n deasserts, REQ-021 SHALL apply from the same cycle, and counters SHALL count from the first rising edge.
REQ-031 If reset asserts mid-stall, the FSM SHALL return to RUN and the counters SHALL clear; no stall is carried over.

Verification
REQ-032 Load-use: EX_MemRead=1, EX_dst=8, ID_opcode=000000, ID_rs=8 -> hazard_detected=1, PC_Write=0 for one cycle; stall_cycles=1; state RUN->STALL1->RUN.
REQ-033 Zero register and rt masking:
 - EX_MemRead=1, EX_dst=0, ID_rs=0 -> hazard_detected=0.
 - ID_opcode=001000 (addi), ID_rt=EX_dst=9, EX_MemRead=1 -> hazard_detected=0.
REQ-034 Branch after load: BEQ in ID with ID_rs=5; cycle 1 EX_MemRead=1, EX_dst=5; cycle 2 MEM_MemRead=1, MEM_dst=5 -> hazard_detected=1 for exactly 2 cycles; stall_cycles=2; hazard_error=0.
REQ-035 Branch after ALU: BEQ, ID_rt=3, EX_RegWrite=1, EX_dst=3, EX_MemRead=0 -> 1 stall cycle.
REQ-036 Flush and saturation:
 - IF_Flush=1 with hz=0 for 3 edges -> flush_cycles=3.
 - IF_Flush=1 with hz=1 -> flush_cycles unchanged.
 - hz held high for 70000 edges -> stall_cycles=16'hFFFF, hazard_error=1.
REQ-037 Async reset: drop rst_n mid-cycle while in STALL2 -> without waiting for a clock edge, state=00, counters=0, hazard_error=0, PC_Write=0.
